// File: rtl/ioblock_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ioblock_bank : WIDTH-pin bidirectional I/O bank sharing one IOCLK, with a
//                serial configuration chain committed atomically on CFG_LOAD.
// Optional feature macro: IOBANK_INFILT_EN (glitch filter on registered input)
// Revision     : 1.0
// ---------------------------------------------------------------------------
module ioblock_bank #(
    parameter int WIDTH = 8
) (
    input  logic             IOCLK,
    input  logic             RST,
    inout  wire  [WIDTH-1:0] PIN,
    input  logic [WIDTH-1:0] TS,
    input  logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] IN,
    input  logic             CFG_EN,
    input  logic             CFG_IN,
    input  logic             CFG_LOAD,
    output logic             CFG_OUT
);

    localparam int CFG_BITS  = 4;
    localparam int CHAIN_LEN = CFG_BITS * WIDTH;

    logic [CHAIN_LEN-1:0] r_shadow;
    logic [CHAIN_LEN-1:0] r_active;
    logic [WIDTH-1:0]     r_tq;
    logic [WIDTH-1:0]     r_oq;
    logic [WIDTH-1:0]     r_d;
    logic [WIDTH-1:0]     w_reg_in;

    // Commit copies the pre-edge shadow, so a coincident shift is not seen.
    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (CFG_EN) begin
                r_shadow <= {CFG_IN, r_shadow[CHAIN_LEN-1:1]};
            end
            if (CFG_LOAD) begin
                r_active <= r_shadow;
            end
        end
    end

    assign CFG_OUT = r_shadow[0];

    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) begin
            r_tq <= '0;
            r_oq <= '0;
            r_d  <= '0;
        end else begin
            r_tq <= TS;
            r_oq <= OUT;
            r_d  <= PIN;
        end
    end

`ifdef IOBANK_INFILT_EN
    // r_d doubles as sampler stage S1; S2's next value is the current S1, so F
    // follows S1 only when the incoming pad sample agrees with it.
    logic [WIDTH-1:0] r_f;
    logic [WIDTH-1:0] w_agree;

    assign w_agree = ~(PIN ^ r_d);

    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) begin
            r_f <= '0;
        end else begin
            r_f <= (r_f & ~w_agree) | (r_d & w_agree);
        end
    end

    assign w_reg_in = r_f;
`else
    assign w_reg_in = r_d;
`endif

    generate
        for (genvar k = 0; k < WIDTH; k++) begin : g_pin
            logic [CFG_BITS-1:0] w_cfg;
            logic                w_te;
            logic                w_od;
            logic                w_drive;

            // Field layout: {OREG, DORREG, TSMUX[1:0]}
            assign w_cfg = r_active[CFG_BITS*k +: CFG_BITS];
            assign w_te  = w_cfg[3] ? r_tq[k] : TS[k];
            assign w_od  = w_cfg[3] ? r_oq[k] : OUT[k];

            always_comb begin
                w_drive = 1'b0;
                case (w_cfg[1:0])
                    2'b00:   w_drive = 1'b0;
                    2'b01:   w_drive = w_te;
                    2'b10:   w_drive = ~w_te;
                    default: w_drive = 1'b1;
                endcase
            end

            assign PIN[k] = w_drive ? w_od : 1'bz;
            assign IN[k]  = w_cfg[2] ? w_reg_in[k] : PIN[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ioblock_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ioblock_bank : self-checking bench for ioblock_bank (WIDTH=8). Pads carry
//                   pull-ups so an undriven pin reads 1; drive checks use OUT=0.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_ioblock_bank;

    localparam int WIDTH = 8;

    logic             IOCLK = 1'b0;
    logic             RST;
    wire  [WIDTH-1:0] PIN;
    logic [WIDTH-1:0] TS;
    logic [WIDTH-1:0] OUT;
    logic [WIDTH-1:0] IN;
    logic             CFG_EN;
    logic             CFG_IN;
    logic             CFG_LOAD;
    logic             CFG_OUT;

    logic [WIDTH-1:0] ext_en;
    logic [WIDTH-1:0] ext_val;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    ioblock_bank #(.WIDTH(WIDTH)) dut (
        .IOCLK    (IOCLK),
        .RST      (RST),
        .PIN      (PIN),
        .TS       (TS),
        .OUT      (OUT),
        .IN       (IN),
        .CFG_EN   (CFG_EN),
        .CFG_IN   (CFG_IN),
        .CFG_LOAD (CFG_LOAD),
        .CFG_OUT  (CFG_OUT)
    );

    always #5 IOCLK = ~IOCLK;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        pullup (PIN[i]);
        assign PIN[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    // Inputs change and outputs are checked on the falling edge.
    task automatic tick();
        @(posedge IOCLK);
        @(negedge IOCLK);
    endtask

    task automatic shift_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            CFG_EN = 1'b1;
            CFG_IN = w[i];
            tick();
        end
        CFG_EN = 1'b0;
        CFG_IN = 1'b0;
    endtask

    task automatic commit();
        CFG_LOAD = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        TS       = WIDTH'($urandom);
        OUT      = '0;
        CFG_EN   = 1'b1;
        CFG_IN   = 1'b1;
        CFG_LOAD = 1'b1;
        ext_en   = '0;
        ext_val  = '0;
        #2;
        n_checks++;
        if (PIN !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_pins_z: got %h expected %h", PIN, 8'hFF);
        end
        n_checks++;
        if (CFG_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cfg_out: got %b expected %b", CFG_OUT, 1'b0);
        end
        ext_en  = 8'hFF;
        ext_val = 8'h5A;
        #1;
        n_checks++;
        if (IN !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_in_mirror_5a: got %h expected %h", IN, 8'h5A);
        end
        tick();
        ext_val = 8'hA5;
        #1;
        n_checks++;
        if (IN !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_in_mirror_a5: got %h expected %h", IN, 8'hA5);
        end
        tick();
        RST      = 1'b0;
        CFG_EN   = 1'b0;
        CFG_IN   = 1'b0;
        CFG_LOAD = 1'b0;
        ext_en   = '0;
        tick();
    endtask

    task automatic test_chain();
        logic [31:0] val;
        logic        e;
        val = 32'hA5C3_0F1E;
        OUT = '0;
        for (int i = 0; i < 32; i++) begin
            TS     = WIDTH'($urandom);
            CFG_EN = 1'b1;
            CFG_IN = val[i];
            exp_q.push_back(val[i]);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (CFG_OUT !== e) begin
                n_fail++;
                $display("FAIL chain_out bit %0d: got %b expected %b", i, CFG_OUT, e);
            end
            n_checks++;
            if (PIN !== 8'hFF) begin
                n_fail++;
                $display("FAIL chain_pins_z bit %0d: got %h expected %h", i, PIN, 8'hFF);
            end
            CFG_EN = 1'b1;
            CFG_IN = 1'b0;
            tick();
        end
        CFG_EN = 1'b0;
        n_checks++;
        if (CFG_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL chain_flushed: got %b expected %b", CFG_OUT, 1'b0);
        end
    endtask

    task automatic test_mode_commit();
        TS  = '0;
        OUT = '0;
        shift_word(32'h0000_0321);
        CFG_LOAD = 1'b1;
        #1;
        n_checks++;
        if (PIN !== 8'hFF) begin
            n_fail++;
            $display("FAIL commit_before_edge: got %h expected %h", PIN, 8'hFF);
        end
        tick();
        CFG_LOAD = 1'b0;
        #1;
        n_checks++;
        if (PIN !== 8'hF9) begin
            n_fail++;
            $display("FAIL commit_ts0_pins: got %h expected %h", PIN, 8'hF9);
        end
        n_checks++;
        if (IN !== 8'hF9) begin
            n_fail++;
            $display("FAIL commit_ts0_in: got %h expected %h", IN, 8'hF9);
        end
        OUT = '1;
        #1;
        n_checks++;
        if (PIN !== 8'hFF) begin
            n_fail++;
            $display("FAIL commit_out1_pins: got %h expected %h", PIN, 8'hFF);
        end
        tick();
        TS  = 8'hFF;
        OUT = '0;
        #1;
        n_checks++;
        if (PIN !== 8'hFA) begin
            n_fail++;
            $display("FAIL commit_ts1_pins: got %h expected %h", PIN, 8'hFA);
        end
        tick();
        TS = 8'h02;
        #1;
        n_checks++;
        if (PIN !== 8'hFB) begin
            n_fail++;
            $display("FAIL commit_ts02_pins: got %h expected %h", PIN, 8'hFB);
        end
        tick();
        TS = '0;
    endtask

    task automatic test_output_register();
        TS  = '0;
        OUT = '0;
        shift_word(32'h0000_000B);
        commit();
        n_checks++;
        if (PIN !== 8'hFE) begin
            n_fail++;
            $display("FAIL oreg_initial: got %h expected %h", PIN, 8'hFE);
        end
        OUT = 8'h01;
        #1;
        n_checks++;
        if (PIN !== 8'hFE) begin
            n_fail++;
            $display("FAIL oreg_before_edge: got %h expected %h", PIN, 8'hFE);
        end
        tick();
        n_checks++;
        if (PIN !== 8'hFF) begin
            n_fail++;
            $display("FAIL oreg_after_edge: got %h expected %h", PIN, 8'hFF);
        end
        OUT = 8'h00;
        #1;
        n_checks++;
        if (PIN !== 8'hFF) begin
            n_fail++;
            $display("FAIL oreg_fall_before: got %h expected %h", PIN, 8'hFF);
        end
        tick();
        n_checks++;
        if (PIN !== 8'hFE) begin
            n_fail++;
            $display("FAIL oreg_fall_after: got %h expected %h", PIN, 8'hFE);
        end
    endtask

    task automatic test_registered_input();
        int   pat[12];
        logic m_s1;
        logic m_f;
        logic e;
        logic prev_exp;
        pat      = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        m_s1     = 1'b0;
        m_f      = 1'b0;
        prev_exp = 1'b0;
        TS       = '0;
        OUT      = '0;
        shift_word(32'h0000_0004);
        commit();
        ext_en  = 8'h01;
        ext_val = 8'h00;
        tick();
        tick();
        for (int c = 0; c < 12; c++) begin
            ext_val[0] = pat[c][0];
`ifdef IOBANK_INFILT_EN
            if (pat[c][0] == m_s1) m_f = m_s1;
            m_s1 = pat[c][0];
            exp_q.push_back(m_f);
`else
            exp_q.push_back(pat[c][0]);
`endif
            #1;
            n_checks++;
            if (IN !== {7'h7F, prev_exp}) begin
                n_fail++;
                $display("FAIL regin_before_edge c=%0d: got %h expected %h", c, IN, {7'h7F, prev_exp});
            end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (IN !== {7'h7F, e}) begin
                n_fail++;
                $display("FAIL regin_after_edge c=%0d: got %h expected %h", c, IN, {7'h7F, e});
            end
            prev_exp = e;
        end
        ext_en  = '0;
        ext_val = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        TS  = '0;
        OUT = '0;
        shift_word(32'h0000_0002);
        n_checks++;
        if (CFG_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_cfg_out_pre: got %b expected %b", CFG_OUT, 1'b0);
        end
        n_checks++;
        if (PIN !== 8'hFF) begin
            n_fail++;
            $display("FAIL simul_pins_pre: got %h expected %h", PIN, 8'hFF);
        end
        CFG_EN   = 1'b1;
        CFG_IN   = 1'b1;
        CFG_LOAD = 1'b1;
        tick();
        CFG_EN   = 1'b0;
        CFG_IN   = 1'b0;
        CFG_LOAD = 1'b0;
        #1;
        n_checks++;
        if (PIN !== 8'hFE) begin
            n_fail++;
            $display("FAIL simul_active_preshift: got %h expected %h", PIN, 8'hFE);
        end
        n_checks++;
        if (CFG_OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_shift_happened: got %b expected %b", CFG_OUT, 1'b1);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        TS  = '0;
        OUT = '0;
        for (int i = 0; i < 10; i++) begin
            CFG_EN = 1'b1;
            CFG_IN = 1'b1;
            tick();
        end
        n_checks++;
        if (PIN !== 8'hFE) begin
            n_fail++;
            $display("FAIL midshift_pins_undisturbed: got %h expected %h", PIN, 8'hFE);
        end
        #1;
        RST = 1'b1;
        #1;
        n_checks++;
        if (PIN !== 8'hFF) begin
            n_fail++;
            $display("FAIL midshift_async_reset_pins: got %h expected %h", PIN, 8'hFF);
        end
        n_checks++;
        if (CFG_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL midshift_cfg_out: got %b expected %b", CFG_OUT, 1'b0);
        end
        tick();
        RST    = 1'b0;
        CFG_EN = 1'b0;
        CFG_IN = 1'b0;
        commit();
        n_checks++;
        if (PIN !== 8'hFF) begin
            n_fail++;
            $display("FAIL midshift_partial_discarded: got %h expected %h", PIN, 8'hFF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_chain();
        test_mode_commit();
        test_output_register();
        test_registered_input();
        test_simultaneous();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ioblock_bank.md
# ioblock_bank

Parametrised bank of WIDTH bidirectional I/O cells sharing one IOCLK, successor to the single-pin I/O cell. Each pin has its own output-enable mode, optional output/tristate register and selectable direct or registered input. Per-pin configuration is loaded through a serial configuration chain into a shadow register. It is committed to the active configuration atomically on a load strobe, so reconfiguration never glitches a pin. The bank sits between fabric logic and the device pads.

## Interface
- WIDTH, 8, number of pins in the bank (1..32)
- CFG_BITS, 4, configuration bits per pin; fixed at 4, not overridable

- IOCLK  input  1  bank clock; all state updates on its rising edge
- RST  input  1  asynchronous, active-high reset
- PIN  inout  WIDTH  pad connections
- TS  input  WIDTH  per-pin fabric tristate control
- OUT  input  WIDTH  per-pin fabric output data
- IN  output  WIDTH  per-pin data to fabric
- CFG_EN  input  1  shift configuration chain one bit this cycle
- CFG_IN  input  1  serial configuration data in
- CFG_LOAD  input  1  commit shadow configuration to active configuration
- CFG_OUT  output  1  serial configuration data out (shadow[0])

## Operation
- Per-pin config field k is shadow[4k+3:4k] = {OREG, DORREG, TSMUX[1:0]}.
- Shift: on a rising edge with CFG_EN=1, shadow <= {CFG_IN, shadow[4*WIDTH-1:1]}.
- CFG_OUT always equals shadow[0], so banks can be daisy-chained.
- Commit: on a rising edge with CFG_LOAD=1, active <= shadow.
  - If CFG_EN and CFG_LOAD are both high, active takes the pre-shift shadow value and the shift still happens.
- Pin behaviour uses the active configuration only. Shifting never disturbs pins.
- Drive enable per pin, from effective TS (te) and data (od):
  - TSMUX=00: never drive
  - TSMUX=01: drive when te=1
  - TSMUX=10: drive when te=0
  - TSMUX=11: always drive
  - Not driving means PIN=z. Driving means PIN=od.
- OREG=0: te=TS[k] and od=OUT[k], combinational.
- OREG=1: te and od come from per-pin registers TQ and OQ. These capture TS[k] and OUT[k] every rising edge.
- Input path: each pin has register D that captures PIN[k] every rising edge.
  - IN[k] = PIN[k] when DORREG=0.
  - IN[k] = D[k] (or the filtered value, see Configuration) when DORREG=1.
- TQ, OQ and D update regardless of OREG/DORREG, so switching mode presents current data immediately.

## Timing
- Reset, asynchronous, effective immediately:
  - shadow=0, active=0, TQ=0, OQ=0, D=0, filter state=0
  - Result: all PIN=z, IN=PIN (combinational), CFG_OUT=0
- RST mid-shift or mid-commit discards the partial configuration. A new full 4*WIDTH-bit shift is required.
- Commit latency: pin behaviour changes the same edge CFG_LOAD is sampled, and is visible immediately after that edge.
- Registered output (OREG=1): a TS/OUT change before edge n appears on PIN after edge n. That is one cycle of latency versus the OREG=0 path.
- Registered input (DORREG=1): a PIN value sampled at edge n appears on IN after edge n.
- Combinational paths: DORREG=0 and OREG=0 paths have zero-cycle latency.
- A full configuration load takes 4*WIDTH shift cycles plus one load cycle (the load may coincide with the cycle after the last shift).

## Configuration
- IOBANK_INFILT_EN defined: each pin adds a glitch filter on the registered input path.
  - Two-stage sampler S1/S2 on PIN[k].
  - Filtered register F[k] updates to S2 only when S1==S2 on that edge; otherwise it holds.
  - With DORREG=1, IN[k]=F[k]. Latency from a stable PIN change to IN is 2 edges; single-cycle pulses are rejected.
  - S1, S2 and F reset to 0.
- IOBANK_INFILT_EN undefined: no filter logic. IN[k]=D[k] with 1-edge latency, and single-cycle pulses pass.

## Test plan
- Reset: assert RST with all inputs random -> all PIN=z, CFG_OUT=0, IN mirrors an externally driven PIN.
- Chain pass-through, WIDTH=8: shift 32 bits 0xA5C3_0F1E LSB first, then 32 zeros -> CFG_OUT reproduces 0xA5C3_0F1E LSB first during the second 32 shifts. Pins stay z throughout (no load).
- Mode commit: load pin0=4'b0001, pin1=4'b0010, pin2=4'b0011, pin3=4'b0000, TS=0, OUT=1 after CFG_LOAD -> PIN[0]=z, PIN[1]=1, PIN[2]=1, PIN[3]=z. Then TS=4'b1111 -> PIN[0]=1, PIN[1]=z.
- Output register: pin0 config 4'b1011, OUT toggles 0->1 before edge n -> PIN[0] still 0 before edge n, 1 after edge n.
- Registered input: pin0 config 4'b0100, external drive 1 before edge n -> IN[0]=0 until edge n, then 1. With IOBANK_INFILT_EN, a 1-cycle high pulse -> IN[0] stays 0, and a 3-cycle high -> IN[0]=1 two edges after the rise.
- Simultaneous events: CFG_EN=1 and CFG_LOAD=1 on one edge -> active equals pre-shift shadow. RST mid-shift -> active=0, pins z.
